// File: rtl/booth_pp_accumulator.sv
// Radix-4 Booth partial-product accumulator: takes one Booth digit per transfer, LSB first,
// and produces a 2*WIDTH signed product. Define BOOTH_ILLEGAL_CHK_EN to build in the illegal-digit flag.
module booth_pp_accumulator #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   mcand,
   input  logic               dig_valid,
   output logic               dig_ready,
   input  logic               dig_neg,
   input  logic               dig_A,
   input  logic               dig_2A,
   output logic               prod_valid,
   input  logic               prod_ready,
   output logic [2*WIDTH-1:0] prod,
   output logic               busy,
   output logic               dig_err,
   output logic [1:0]         state_dbg
);

   localparam int PW   = 2 * WIDTH;
   localparam int NDIG = WIDTH / 2;
   localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Handshakes: a digit moves on a cycle with dig_valid && dig_ready; the product
   // moves on a cycle with prod_valid && prod_ready. Neither valid may depend on ready.
   state_t            state, state_next;
   logic [WIDTH-1:0]  mcand_q;
   logic [PW-1:0]     acc;
   logic [KW-1:0]     k;
   logic [PW-1:0]     mcand_ext;
   logic [PW-1:0]     mag;
   logic [PW-1:0]     pp;
   logic [PW-1:0]     pp_shift;
   logic [PW-1:0]     acc_next;
   logic              dig_xfer;
   logic              last_dig;
   logic              start_acc;

   assign dig_xfer  = dig_valid && dig_ready;
   assign last_dig  = (k == KW'(NDIG - 1));
   assign start_acc = (state == S_IDLE) && start;

   // Partial product: sign-extend, pick 0/1x/2x, negate in two's complement, weight by 4^k.
   assign mcand_ext = {{WIDTH{mcand_q[WIDTH-1]}}, mcand_q};
   assign mag       = dig_2A ? {mcand_ext[PW-2:0], 1'b0} : (dig_A ? mcand_ext : '0);
   assign pp        = dig_neg ? (~mag + PW'(1)) : mag;
   assign pp_shift  = pp << {k, 1'b0};
   assign acc_next  = acc + pp_shift;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (start) state_next = S_ACC;
         S_ACC:   if (dig_xfer && last_dig) state_next = S_DONE;
         S_DONE:  if (prod_ready) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      dig_ready  = 1'b0;
      prod_valid = 1'b0;
      busy       = 1'b0;
      case (state)
         S_ACC:   begin dig_ready  = 1'b1; busy = 1'b1; end
         S_DONE:  begin prod_valid = 1'b1; busy = 1'b1; end
         default: ;
      endcase
   end

   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_q <= '0;
         acc     <= '0;
         k       <= '0;
         prod    <= '0;
      end else if (start_acc) begin
         mcand_q <= mcand;
         acc     <= '0;
         k       <= '0;
      end else if (dig_xfer) begin
         acc <= acc_next;
         k   <= k + KW'(1);
         if (last_dig) prod <= acc_next;
      end
   end

`ifdef BOOTH_ILLEGAL_CHK_EN
   logic dig_illegal;
   assign dig_illegal = (dig_A && dig_2A) || (dig_neg && !dig_A && !dig_2A);

   // Sticky until the next accepted start so the consumer can read it alongside prod.
   always_ff @(posedge clk) begin
      if (rst)                          dig_err <= 1'b0;
      else if (start_acc)               dig_err <= 1'b0;
      else if (dig_xfer && dig_illegal) dig_err <= 1'b1;
   end
`else
   assign dig_err = 1'b0;
`endif

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Directed bench for booth_pp_accumulator (WIDTH=8); inputs change 1 time unit after
// the rising edge and outputs are sampled there too.
module tb_booth_pp_accumulator;

   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           start = 1'b0;
   logic [W-1:0]   mcand = '0;
   logic           dig_valid = 1'b0;
   logic           dig_ready;
   logic           dig_neg = 1'b0;
   logic           dig_A = 1'b0;
   logic           dig_2A = 1'b0;
   logic           prod_valid;
   logic           prod_ready = 1'b0;
   logic [2*W-1:0] prod;
   logic           busy;
   logic           dig_err;
   logic [1:0]     state_dbg;

   int checks = 0;
   int failures = 0;

   booth_pp_accumulator #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .mcand(mcand),
      .dig_valid(dig_valid), .dig_ready(dig_ready),
      .dig_neg(dig_neg), .dig_A(dig_A), .dig_2A(dig_2A),
      .prod_valid(prod_valid), .prod_ready(prod_ready), .prod(prod),
      .busy(busy), .dig_err(dig_err), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [W-1:0] m);
      start = 1'b1;
      mcand = m;
      tick();
      start = 1'b0;
      mcand = 8'hA5;
   endtask

   // d = {neg, A, 2A}; during gaps the digit lines carry junk with dig_valid low.
   task automatic send_digit(input logic [2:0] d, input int gap);
      {dig_neg, dig_A, dig_2A} = d;
      dig_valid = 1'b1;
      tick();
      dig_valid = 1'b0;
      {dig_neg, dig_A, dig_2A} = 3'b010;
      repeat (gap) tick();
   endtask

   task automatic release_prod();
      prod_ready = 1'b1;
      tick();
      prod_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if (state_dbg !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
      checks++;
      if ({dig_ready, prod_valid, busy, dig_err} !== 4'b0000) begin
         failures++; $display("FAIL reset_flags got=%b exp=0000", {dig_ready, prod_valid, busy, dig_err});
      end
      checks++;
      if (prod !== 16'h0000) begin failures++; $display("FAIL reset_prod got=%h exp=0000", prod); end
   endtask

   task automatic test_basic();
      do_start(8'd5);
      checks++;
      if ({state_dbg, dig_ready, busy} !== 4'b0111) begin
         failures++; $display("FAIL basic_acc got=%b exp=0111", {state_dbg, dig_ready, busy});
      end
      send_digit(3'b110, 0);
      send_digit(3'b010, 0);
      send_digit(3'b000, 0);
      checks++;
      if (prod_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", prod_valid); end
      send_digit(3'b000, 0);
      checks++;
      if ({prod_valid, dig_ready, state_dbg} !== 4'b1010) begin
         failures++; $display("FAIL basic_done got=%b exp=1010", {prod_valid, dig_ready, state_dbg});
      end
      checks++;
      if (prod !== 16'h000F) begin failures++; $display("FAIL basic_prod got=%h exp=000f", prod); end
      release_prod();
      checks++;
      if ({prod_valid, busy, state_dbg} !== 4'b0000) begin
         failures++; $display("FAIL basic_exit got=%b exp=0000", {prod_valid, busy, state_dbg});
      end
      checks++;
      if (prod !== 16'h000F) begin failures++; $display("FAIL basic_retain got=%h exp=000f", prod); end
   endtask

   task automatic test_min_square();
      do_start(8'h80);
      send_digit(3'b000, 0);
      send_digit(3'b000, 0);
      send_digit(3'b000, 0);
      send_digit(3'b101, 0);
      checks++;
      if (prod_valid !== 1'b1 || prod !== 16'h4000) begin
         failures++; $display("FAIL min_square got=%b/%h exp=1/4000", prod_valid, prod);
      end
      release_prod();
   endtask

   task automatic test_gaps();
      logic gap_ok;
      gap_ok = 1'b1;
      do_start(8'd127);
      send_digit(3'b110, 0);
      for (int i = 0; i < 3; i++) begin
         repeat (2) begin
            tick();
            if (dig_ready !== 1'b1 || prod_valid !== 1'b0) gap_ok = 1'b0;
         end
         send_digit(3'b000, 0);
      end
      checks++;
      if (gap_ok !== 1'b1) begin failures++; $display("FAIL gaps_hold got=%b exp=1", gap_ok); end
      checks++;
      if (prod_valid !== 1'b1 || prod !== 16'hFF81) begin
         failures++; $display("FAIL gaps_prod got=%b/%h exp=1/ff81", prod_valid, prod);
      end
      release_prod();
   endtask

   task automatic test_done_hold();
      do_start(8'hFD);
      send_digit(3'b110, 0);
      send_digit(3'b001, 0);
      send_digit(3'b000, 0);
      send_digit(3'b000, 0);
      checks++;
      if (prod !== 16'hFFEB) begin failures++; $display("FAIL hold_prod got=%h exp=ffeb", prod); end
      start = 1'b1;
      mcand = 8'd9;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({prod_valid, state_dbg} !== 3'b110 || prod !== 16'hFFEB) begin
            failures++; $display("FAIL hold_cycle%0d got=%b/%h exp=110/ffeb", i, {prod_valid, state_dbg}, prod);
         end
      end
      release_prod();
      checks++;
      if ({prod_valid, busy, state_dbg} !== 4'b0000) begin
         failures++; $display("FAIL hold_exit got=%b exp=0000", {prod_valid, busy, state_dbg});
      end
      start = 1'b0;
      tick();
      checks++;
      if (state_dbg !== 2'd0) begin failures++; $display("FAIL hold_no_start got=%0d exp=0", state_dbg); end
   endtask

   task automatic test_reset_mid();
      do_start(8'd100);
      send_digit(3'b010, 0);
      send_digit(3'b010, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({state_dbg, dig_ready, prod_valid, busy, dig_err} !== 6'b0) begin
         failures++; $display("FAIL midrst_flags got=%b exp=000000", {state_dbg, dig_ready, prod_valid, busy, dig_err});
      end
      checks++;
      if (prod !== 16'h0000) begin failures++; $display("FAIL midrst_prod got=%h exp=0000", prod); end
      do_start(8'd6);
      send_digit(3'b110, 0);
      send_digit(3'b001, 0);
      send_digit(3'b000, 0);
      send_digit(3'b000, 0);
      checks++;
      if (prod_valid !== 1'b1 || prod !== 16'h002A) begin
         failures++; $display("FAIL midrst_fresh got=%b/%h exp=1/002a", prod_valid, prod);
      end
      release_prod();
   endtask

   task automatic test_illegal();
      logic exp_err;
`ifdef BOOTH_ILLEGAL_CHK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      do_start(8'd3);
      checks++;
      if (dig_err !== 1'b0) begin failures++; $display("FAIL illegal_pre got=%b exp=0", dig_err); end
      send_digit(3'b011, 0);
      checks++;
      if (dig_err !== exp_err) begin failures++; $display("FAIL illegal_flag got=%b exp=%b", dig_err, exp_err); end
      send_digit(3'b000, 0);
      send_digit(3'b000, 0);
      send_digit(3'b000, 0);
      checks++;
      if (prod !== 16'h0006 || dig_err !== exp_err) begin
         failures++; $display("FAIL illegal_done got=%h/%b exp=0006/%b", prod, dig_err, exp_err);
      end
      release_prod();
      checks++;
      if (dig_err !== exp_err) begin failures++; $display("FAIL illegal_idle got=%b exp=%b", dig_err, exp_err); end
      do_start(8'd0);
      checks++;
      if (dig_err !== 1'b0) begin failures++; $display("FAIL illegal_clear got=%b exp=0", dig_err); end
      repeat (4) send_digit(3'b000, 0);
      release_prod();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_min_square();
      test_gaps();
      test_done_hold();
      test_reset_mid();
      test_illegal();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/booth_pp_accumulator.md
BOOTH_PP_ACCUMULATOR -- requirements
Module: booth_pp_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 8: signed operand width; even, >= 4.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin a new product; sampled only in IDLE.
REQ-005 SHALL have port mcand  input  WIDTH  signed multiplicand, captured when start is accepted.
REQ-006 SHALL have port dig_valid  input  1  a Booth digit is presented.
REQ-007 SHALL have port dig_ready  output  1  block accepts a digit this cycle.
REQ-008 SHALL have port dig_neg  input  1  digit control: negate the selected multiple.
REQ-009 SHALL have port dig_A  input  1  digit control: select 1x multiplicand.
REQ-010 SHALL have port dig_2A  input  1  digit control: select 2x multiplicand.
REQ-011 SHALL have port prod_valid  output  1  product is available.
REQ-012 SHALL have port prod_ready  input  1  consumer accepts the product.
REQ-013 SHALL have port prod  output  2*WIDTH  signed product.
REQ-014 SHALL have port busy  output  1  high in ACC or DONE.
REQ-015 SHALL have port dig_err  output  1  illegal-digit flag (see Configuration).

Function
REQ-016 SHALL implement a three-state FSM: IDLE, ACC and DONE.
REQ-017 SHALL move from IDLE to ACC when start=1, capturing mcand, clearing the accumulator and setting digit index k=0.
REQ-018 SHALL drive dig_ready=1 only in ACC; a digit transfers on a cycle where dig_valid and dig_ready are both 1.
REQ-019 SHALL allow idle cycles between digits (dig_valid=0); in that case the accumulator and k hold.
REQ-020 SHALL consume digits LSB-first; digit k adds pp<<(2k) to the accumulator, where pp is sign-extended to 2*WIDTH bits.
REQ-021 SHALL form pp as magnitude = 2*mcand if dig_2A, else mcand if dig_A, else 0; pp is the exact two's-complement negation of magnitude when dig_neg=1.
REQ-022 SHALL compute all arithmetic modulo 2^(2*WIDTH); the result SHALL equal mcand*multiplier for every signed WIDTH-bit pair, including -2^(WIDTH-1) squared.
REQ-023 SHALL go from ACC to DONE on the transfer of digit WIDTH/2-1; prod_valid=1 and prod final on the next cycle.
REQ-024 SHALL hold prod stable with prod_valid=1 in DONE until prod_ready=1, then return to IDLE with prod_valid=0 on the following cycle.
REQ-025 SHALL ignore start in ACC and DONE; start is not accepted in the same cycle that DONE exits.
REQ-026 SHALL drive prod_valid=0 outside DONE; prod retains its last value after leaving DONE.

Reset
REQ-027 SHALL on rst=1, at the next clock edge and regardless of state (including mid-ACC), force state to IDLE, the accumulator, prod, k and captured mcand to 0, and dig_ready, prod_valid, busy and dig_err to 0.
REQ-028 SHALL give rst priority over start, over the digit handshake and over the product handshake.

Configuration
REQ-029 SHALL use macro BOOTH_ILLEGAL_CHK_EN to compile the illegal-digit check in or out.
REQ-030 With BOOTH_ILLEGAL_CHK_EN defined, a transferred digit with dig_A=dig_2A=1, or with dig_neg=1 and dig_A=dig_2A=0, SHALL set dig_err=1 on the next cycle; dig_err stays set until the next accepted start or rst, and the digit is still accumulated per REQ-021.
REQ-031 Without BOOTH_ILLEGAL_CHK_EN, dig_err SHALL be constant 0 and no check logic SHALL exist.

Verification (WIDTH=8)
REQ-032 SHALL cover: mcand=5, digits (neg,A,2A)=110,010,000,000 -> prod=0x000F, prod_valid exactly one cycle after the 4th digit transfer.
REQ-033 SHALL cover: mcand=-128, digits 000,000,000,101 -> prod=0x4000.
REQ-034 SHALL cover: mcand=127, digits 110,000,000,000 with dig_valid low 2 cycles between digits -> prod=0xFF81, accumulator holds during gaps.
REQ-035 SHALL cover: prod_ready held low 3 cycles in DONE, with start pulsed -> prod and prod_valid stable, start ignored, IDLE after prod_ready=1.
REQ-036 SHALL cover: rst asserted after 2 digit transfers -> next cycle all outputs 0 and state IDLE; a fresh product then computes correctly.
REQ-037 SHALL cover, with BOOTH_ILLEGAL_CHK_EN: digit 011 -> dig_err=1 next cycle, held through DONE, cleared by the next start.
